// File: rtl/sm4_din_pack.sv
// sm4_din_pack: packs a 32-bit word stream into 128-bit blocks
// and issues each block to sm4_core once it is keyed and idle.
module sm4_din_pack #(
  parameter int BLK_CNT_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_key_ok,
  input  logic [31:0]          i_word,
  input  logic                 i_word_en,
  input  logic                 i_last,
  output logic                 o_word_rdy,
  output logic [127:0]         o_din,
  output logic                 o_din_en,
  output logic                 o_din_last,
  output logic [1:0]           o_pad_words,
  input  logic                 i_core_done,
  output logic                 o_busy,
  output logic [BLK_CNT_W-1:0] o_blk_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [127:0]   fill_buf;
  logic [127:0]   buf_d;
  logic [1:0]     wcnt;
  logic           full;
  logic           last_f;
  logic [1:0]     pad_f;
  logic           accept;
  logic           close;
  logic           issue;

  assign o_word_rdy = ~full;
  assign o_busy     = (state_q == BUSY);
  assign accept     = i_word_en & ~full;
  assign close      = accept & (i_last | (wcnt == 2'd3));

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (full & i_key_ok) begin
          issue   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (i_core_done) state_d = IDLE;
      end
    endcase
  end

  // Closing word lands in its slot; every later slot is zero-padded.
  always_comb begin
    buf_d = fill_buf;
    for (int i = 0; i < 4; i++) begin
      if (accept && (wcnt == i[1:0]))
        buf_d[127-32*i -: 32] = i_word;
      else if (close && (i[1:0] > wcnt))
        buf_d[127-32*i -: 32] = 32'h0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      fill_buf    <= '0;
      wcnt        <= '0;
      full        <= 1'b0;
      last_f      <= 1'b0;
      pad_f       <= '0;
      o_din       <= '0;
      o_din_en    <= 1'b0;
      o_din_last  <= 1'b0;
      o_pad_words <= '0;
      o_blk_cnt   <= '0;
    end else begin
      state_q  <= state_d;
      o_din_en <= issue;
      if (accept) begin
        fill_buf <= buf_d;
        if (close) begin
          full   <= 1'b1;
          last_f <= i_last;
          pad_f  <= 2'd3 - wcnt;
          wcnt   <= 2'd0;
        end else begin
          wcnt <= wcnt + 2'd1;
        end
      end
      if (issue) begin
        o_din       <= fill_buf;
        o_din_last  <= last_f;
        o_pad_words <= pad_f;
        full        <= 1'b0;
        o_blk_cnt   <= o_blk_cnt + BLK_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sm4_din_pack.sv
// Scoreboard bench for sm4_din_pack: expected blocks are queued
// with their issue edge; a negedge monitor pops and compares.
module tb_sm4_din_pack;

  logic         clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_key_ok = 1'b0;
  logic [31:0]  i_word = '0;
  logic         i_word_en = 1'b0;
  logic         i_last = 1'b0;
  logic         o_word_rdy;
  logic [127:0] o_din;
  logic         o_din_en;
  logic         o_din_last;
  logic [1:0]   o_pad_words;
  logic         i_core_done = 1'b0;
  logic         o_busy;
  logic [1:0]   o_blk_cnt;

  sm4_din_pack #(.BLK_CNT_W(2)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_key_ok    (i_key_ok),
    .i_word      (i_word),
    .i_word_en   (i_word_en),
    .i_last      (i_last),
    .o_word_rdy  (o_word_rdy),
    .o_din       (o_din),
    .o_din_en    (o_din_en),
    .o_din_last  (o_din_last),
    .o_pad_words (o_pad_words),
    .i_core_done (i_core_done),
    .o_busy      (o_busy),
    .o_blk_cnt   (o_blk_cnt)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    logic [127:0] din;
    logic         last;
    logic [1:0]   pad;
    logic [1:0]   cnt;
    int           at;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  logic [1:0] exp_cnt = '0;
  int         npass = 0;
  int         ntot = 0;
  int         ce;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic push(input logic [127:0] din,
                      input logic last,
                      input logic [1:0] pad,
                      input int at);
    exp_cnt = exp_cnt + 2'd1;
    q.push_back('{din, last, pad, exp_cnt, at});
  endtask

  always @(negedge clk) begin
    if (o_din_en !== 1'b0) begin
      if (q.size() == 0) begin
        chk("unexpected_issue", {127'b0, o_din_en}, 128'd0);
      end else begin
        e = q.pop_front();
        chk("din", o_din, e.din);
        chk("din_last", {127'b0, o_din_last}, {127'b0, e.last});
        chk("pad_words", {126'b0, o_pad_words}, {126'b0, e.pad});
        chk("blk_cnt", {126'b0, o_blk_cnt}, {126'b0, e.cnt});
        chk("issue_edge", 128'(edge_n), 128'(e.at));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [31:0] w, input logic last);
    int n;
    n = 0;
    i_word    = w;
    i_last    = last;
    i_word_en = 1'b1;
    while (o_word_rdy !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("rdy_timeout", 128'd0, 128'd1);
    @(posedge clk);
    @(negedge clk);
    i_word_en = 1'b0;
    i_last    = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("issue_timeout", 128'(q.size()), 128'd0);
      q.delete();
    end
  endtask

  task automatic done_pulse();
    i_core_done = 1'b1;
    @(negedge clk);
    i_core_done = 1'b0;
  endtask

  task automatic chk_reset_outs();
    chk("rst_din", o_din, 128'd0);
    chk("rst_din_en", {127'b0, o_din_en}, 128'd0);
    chk("rst_last", {127'b0, o_din_last}, 128'd0);
    chk("rst_pad", {126'b0, o_pad_words}, 128'd0);
    chk("rst_busy", {127'b0, o_busy}, 128'd0);
    chk("rst_cnt", {126'b0, o_blk_cnt}, 128'd0);
    chk("rst_rdy", {127'b0, o_word_rdy}, 128'd1);
    chk("rst_wcnt", {126'b0, dut.wcnt}, 128'd0);
    chk("rst_full", {127'b0, dut.full}, 128'd0);
  endtask

  logic [31:0]  bw [2][4];
  logic [127:0] bd [2];
  logic [31:0]  ww [4];

  initial begin
    bw[0] = '{32'ha0a0a0a0, 32'hb1b1b1b1,
              32'hc2c2c2c2, 32'hd3d3d3d3};
    bw[1] = '{32'h5a5a5a5a, 32'h6b6b6b6b,
              32'h7c7c7c7c, 32'h8d8d8d8d};
    bd[0] = 128'ha0a0a0a0_b1b1b1b1_c2c2c2c2_d3d3d3d3;
    bd[1] = 128'h5a5a5a5a_6b6b6b6b_7c7c7c7c_8d8d8d8d;

    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    chk_reset_outs();

    // basic pack
    i_key_ok = 1'b1;
    send(32'h01234567, 1'b0);
    send(32'h89abcdef, 1'b0);
    send(32'hfedcba98, 1'b0);
    send(32'h76543210, 1'b0);
    ce = edge_n;
    push(128'h01234567_89abcdef_fedcba98_76543210,
         1'b0, 2'd0, ce + 1);
    wait_empty();
    chk("busy_after_issue", {127'b0, o_busy}, 128'd1);
    done_pulse();
    chk("busy_after_done", {127'b0, o_busy}, 128'd0);

    // short final blocks
    send(32'haabbccdd, 1'b0);
    send(32'h11223344, 1'b1);
    ce = edge_n;
    push(128'haabbccdd_11223344_00000000_00000000,
         1'b1, 2'd2, ce + 1);
    wait_empty();
    done_pulse();
    send(32'h55667788, 1'b1);
    ce = edge_n;
    push(128'h55667788_00000000_00000000_00000000,
         1'b1, 2'd3, ce + 1);
    wait_empty();
    done_pulse();

    // key gating; stray i_last without i_word_en must not count
    i_key_ok = 1'b0;
    i_last   = 1'b1;
    repeat (2) @(negedge clk);
    send(32'hcafef00d, 1'b0);
    send(32'hdeadbeef, 1'b0);
    send(32'h0badc0de, 1'b0);
    send(32'h12345678, 1'b0);
    repeat (4) @(negedge clk);
    chk("gated_rdy", {127'b0, o_word_rdy}, 128'd0);
    chk("gated_busy", {127'b0, o_busy}, 128'd0);
    i_key_ok = 1'b1;
    push(128'hcafef00d_deadbeef_0badc0de_12345678,
         1'b0, 2'd0, edge_n + 1);
    wait_empty();
    done_pulse();

    // overlap: B and C collected while previous block in flight
    send(32'h11111111, 1'b0);
    send(32'h22222222, 1'b0);
    send(32'h33333333, 1'b0);
    send(32'h44444444, 1'b0);
    ce = edge_n;
    push(128'h11111111_22222222_33333333_44444444,
         1'b0, 2'd0, ce + 1);
    wait_empty();
    for (int b = 0; b < 2; b++) begin
      for (int j = 0; j < 4; j++) send(bw[b][j], 1'b0);
      chk("bp_rdy", {127'b0, o_word_rdy}, 128'd0);
      repeat (2) @(negedge clk);
      chk("bp_rdy_hold", {127'b0, o_word_rdy}, 128'd0);
      chk("bp_busy", {127'b0, o_busy}, 128'd1);
      push(bd[b], 1'b0, 2'd0, edge_n + 2);
      done_pulse();
      chk("done_full_busy", {127'b0, o_busy}, 128'd0);
      chk("done_full_en", {127'b0, o_din_en}, 128'd0);
      wait_empty();
    end
    done_pulse();

    // spurious done while idle
    done_pulse();
    chk("spur_busy", {127'b0, o_busy}, 128'd0);
    chk("spur_cnt", {126'b0, o_blk_cnt}, {126'b0, exp_cnt});
    chk("spur_din", o_din, bd[1]);

    // reset mid-block
    send(32'hdeaddead, 1'b0);
    send(32'hbeefbeef, 1'b0);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    exp_cnt = '0;
    chk_reset_outs();
    send(32'h0f0f0f0f, 1'b0);
    send(32'h1e1e1e1e, 1'b0);
    send(32'h2d2d2d2d, 1'b0);
    send(32'h3c3c3c3c, 1'b0);
    ce = edge_n;
    push(128'h0f0f0f0f_1e1e1e1e_2d2d2d2d_3c3c3c3c,
         1'b0, 2'd0, ce + 1);
    wait_empty();

    // reset while busy, then a stale done
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    exp_cnt = '0;
    chk("rst_busy2", {127'b0, o_busy}, 128'd0);
    done_pulse();
    chk("stale_busy", {127'b0, o_busy}, 128'd0);
    chk("stale_cnt", {126'b0, o_blk_cnt}, 128'd0);

    // counter wrap: 1,2,3,0,1
    for (int b = 0; b < 5; b++) begin
      for (int j = 0; j < 4; j++) begin
        ww[j] = {8'(b), 8'(j), 16'h5eed};
        send(ww[j], 1'b0);
      end
      ce = edge_n;
      push({ww[0], ww[1], ww[2], ww[3]}, 1'b0, 2'd0, ce + 1);
      wait_empty();
      done_pulse();
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 128'(q.size()), 128'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
